// File: rtl/if_id_skid_reg_pkg.sv
// if_id_pkg: shared widths, fetch beat layout and skid-buffer state encoding
package if_id_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_beat_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} skid_state_t;
endpackage

// File: rtl/if_id_skid_reg_if.sv
// if_id_skid_reg_if: fetch-side and decode-side handshake bundle
interface if_id_skid_reg_if #(parameter int XLEN = 32);
  logic in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic in_ready;
  logic out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic out_ready;
  logic flush;
  logic [1:0] occ;
  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input in_ready, out_valid, out_pc, out_instr, occ
  );
  modport slave (
    input in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, occ
  );
endinterface

// File: rtl/if_id_skid_reg_pipe_entry.sv
// pipe_entry: one fetch beat register with load, sync clear and async reset to {0, NOP}
module pipe_entry
  import if_id_pkg::*;
#(
  parameter fetch_beat_t RST_VAL = '{pc: '0, instr: NOP_INSTR_DEF}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        clr,
  input  fetch_beat_t d,
  output fetch_beat_t q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (ld) q <= d;
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: fetch-to-decode register with one skid entry and flush
module if_id_skid_reg
  import if_id_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input logic clk,
  input logic rst,
  if_id_skid_reg_if.slave bus
);
  localparam fetch_beat_t BEAT_RST = '{pc: '0, instr: NOP_INSTR};
  skid_state_t state;
  fetch_beat_t in_beat, main_d, main_q, skid_q;
  logic in_fire, out_fire, main_ld, main_clr, skid_ld;
  assign in_beat = '{pc: bus.in_pc, instr: bus.in_instr};
  assign bus.in_ready = state != SKID;
  assign bus.out_valid = state != EMPTY;
  assign bus.occ = state;
  assign bus.out_pc = main_q.pc;
  assign bus.out_instr = main_q.instr;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign main_d = state == SKID ? skid_q : in_beat;
  assign main_ld = (state == EMPTY & in_fire) | (state == FULL & in_fire & out_fire) | (state == SKID & out_fire);
  // draining the last beat clears main so decode never sees a stale instruction
  assign main_clr = bus.flush | (state == FULL & !in_fire & out_fire);
  assign skid_ld = state == FULL & in_fire & !out_fire;
  pipe_entry #(.RST_VAL(BEAT_RST)) u_main (
    .clk(clk), .rst(rst), .ld(main_ld), .clr(main_clr), .d(main_d), .q(main_q)
  );
  pipe_entry #(.RST_VAL(BEAT_RST)) u_skid (
    .clk(clk), .rst(rst), .ld(skid_ld), .clr(bus.flush), .d(in_beat), .q(skid_q)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else if (bus.flush) state <= EMPTY;
    else
      case (state)
        EMPTY: state <= in_fire ? FULL : EMPTY;
        FULL: state <= in_fire & !out_fire ? SKID : !in_fire & out_fire ? EMPTY : FULL;
        SKID: state <= out_fire ? FULL : SKID;
        default: state <= EMPTY;
      endcase
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: directed + random handshake bench against a queue model
module tb_if_id_skid_reg;
  logic clk = 0;
  logic rst = 0;
  int vectors = 0;
  int errors = 0;
  logic [63:0] q[$];
  if_id_skid_reg_if #(.XLEN(32)) bus ();
  if_id_skid_reg dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // queue model: up to two beats in acceptance order, head is what decode sees
  always @(posedge clk or negedge rst) begin
    if (!rst) q.delete();
    else if (bus.flush) q.delete();
    else begin
      automatic bit acc = bus.in_valid && q.size() < 2;
      if (bus.out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back({bus.in_pc, bus.in_instr});
    end
  end
  always @(negedge clk) begin
    automatic int n = q.size();
    chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
    chk("out_pc", bus.out_pc, n > 0 ? q[0][63:32] : 32'h0);
    chk("out_instr", bus.out_instr, n > 0 ? q[0][31:0] : 32'h13);
    chk("occ", 32'(bus.occ), 32'(n));
    chk("in_ready", 32'(bus.in_ready), 32'(n < 2));
  end
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy, input logic fl);
    bus.in_valid = v;
    bus.in_pc = pc;
    bus.in_instr = ins;
    bus.out_ready = rdy;
    bus.flush = fl;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1, 32'h100, 32'h00500093, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_instr", bus.out_instr, 32'h13);
    chk("rst out_pc", bus.out_pc, 0);
    chk("rst in_ready", 32'(bus.in_ready), 1);
    chk("rst occ", 32'(bus.occ), 0);
    rst = 1;
    step();
    chk("first out_valid", 32'(bus.out_valid), 1);
    chk("first out_pc", bus.out_pc, 32'h100);
    chk("first out_instr", bus.out_instr, 32'h00500093);
    drive(0, 0, 0, 1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'h1000 + 32'(i), 1, 0);
      step();
      chk("stream out_pc", bus.out_pc, 32'(i * 4));
      chk("stream occ", 32'(bus.occ), 1);
      chk("stream in_ready", 32'(bus.in_ready), 1);
    end
    drive(0, 0, 0, 1, 0);
    step();
    drive(1, 32'h10, 32'h2010, 0, 0);
    step();
    drive(1, 32'h14, 32'h2014, 0, 0);
    step();
    chk("skid occ", 32'(bus.occ), 2);
    chk("skid in_ready", 32'(bus.in_ready), 0);
    chk("skid out_pc", bus.out_pc, 32'h10);
    drive(0, 0, 0, 1, 0);
    step();
    chk("drain1 out_pc", bus.out_pc, 32'h14);
    chk("drain1 in_ready", 32'(bus.in_ready), 1);
    step();
    chk("drain2 out_valid", 32'(bus.out_valid), 0);
    drive(1, 32'h18, 32'h2018, 0, 0);
    step();
    drive(1, 32'h1c, 32'h201c, 0, 0);
    step();
    chk("preflush occ", 32'(bus.occ), 2);
    drive(1, 32'h20, 32'h2020, 0, 1);
    step();
    chk("flush out_valid", 32'(bus.out_valid), 0);
    chk("flush occ", 32'(bus.occ), 0);
    chk("flush in_ready", 32'(bus.in_ready), 1);
    chk("flush out_instr", bus.out_instr, 32'h13);
    drive(0, 0, 0, 1, 0);
    step();
    chk("postflush out_valid", 32'(bus.out_valid), 0);
    drive(1, 32'h30, 32'h2030, 0, 0);
    step();
    drive(1, 32'h34, 32'h2034, 0, 0);
    step();
    chk("prereset occ", 32'(bus.occ), 2);
    #1 rst = 0;
    #1;
    chk("async out_valid", 32'(bus.out_valid), 0);
    chk("async occ", 32'(bus.occ), 0);
    chk("async out_instr", bus.out_instr, 32'h13);
    step();
    rst = 1;
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h4000 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
      step();
    end
    drive(0, 0, 0, 1, 0);
    repeat (3) step();
    chk("final occ", 32'(bus.occ), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Fetch-to-decode pipeline register for the RISC-V core, placed directly downstream of instruction fetch.
- Captures {pc, instr} beats with a valid/ready handshake.
- Holds one extra "skid" entry so that in_ready is a registered signal and full throughput is kept under decode back-pressure.
- Supports a synchronous flush for branch and jump redirects.

Parameters:
- XLEN, 32, width of pc and instr fields.
- NOP_INSTR, 32'h0000_0013, value driven on out_instr when no beat is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch presents a beat.
- in_pc  input  XLEN  pc of the incoming beat.
- in_instr  input  XLEN  instruction word of the incoming beat.
- in_ready  output  1  block can accept a beat this cycle.
- out_valid  output  1  decode-side beat available.
- out_pc  output  XLEN  pc of the held beat.
- out_instr  output  XLEN  instruction of the held beat.
- out_ready  input  1  decode consumes the beat this cycle.
- flush  input  1  discard all held beats (redirect).
- occ  output  2  number of beats held (0..2).

Behaviour:
- Reset (rst=0, asynchronous): state=EMPTY, main and skid entries invalid, out_pc=0, out_instr=NOP_INSTR, out_valid=0, occ=0, in_ready=1. The same values hold for as long as rst stays low.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs are driven only from the main entry. The skid entry is never visible on the outputs.
- in_ready = (state != SKID). It is a decode of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). occ = 0, 1 or 2 for EMPTY, FULL and SKID respectively.
- State transitions (evaluated at posedge, flush=0):
  - EMPTY: in_fire -> FULL, main<=in. Otherwise stay EMPTY.
  - FULL: in_fire & out_fire -> FULL, main<=in. in_fire & !out_fire -> SKID, skid<=in, main unchanged. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - SKID: in_fire is impossible. out_fire -> FULL, main<=skid. Otherwise hold.
- Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle). Sustained throughput is 1 beat/cycle when out_ready=1.
- Ordering: beats leave in strict acceptance order and are never duplicated or dropped except by flush.
- Flush has top priority:
  - On a posedge with flush=1: state<=EMPTY, both entries invalid, out_instr<=NOP_INSTR, out_pc<=0.
  - A simultaneous in_fire beat is dropped and a simultaneous out_fire is still counted as consumed by decode.
  - in_ready=1 in the cycle after the flush.
- Invalid entries: when the main entry is invalid, out_pc=0 and out_instr=NOP_INSTR, so decode never sees stale data.
- Data registers load only on the transitions listed above and hold otherwise. in_* values while in_valid=0 are ignored.
- Reset asserted mid-operation: all beats are lost immediately, without waiting for a clock edge.
- No X propagation: every register has a defined reset value.

Decomposition:
- Package if_id_pkg:
  - XLEN_DEF=32 and NOP_INSTR_DEF=32'h0000_0013.
  - Typedef fetch_beat_t packing {pc, instr}.
  - Enum skid_state_t {EMPTY, FULL, SKID} as 2-bit encoding 0/1/2.
- One sub-module, pipe_entry: a fetch_beat_t register with load enable, synchronous clear (for flush) and async active-low reset to {0, NOP}. It is instantiated twice, once for main and once for skid.
- The top module holds the FSM, the handshake decode and the mux selecting in vs skid into main.

Test Plan:
- Reset check: hold rst=0 for 2 cycles while in_valid=1 -> out_valid=0, out_instr=32'h13, out_pc=0, in_ready=1, occ=0. Release reset and present pc=0x100, instr=0x00500093 -> after 1 edge out_valid=1, out_pc=0x100, out_instr=0x00500093.
- Streaming: out_ready=1 with 4 back-to-back beats pc=0x0,0x4,0x8,0xC -> each appears exactly 1 cycle after acceptance, in_ready stays 1, occ stays 1.
- Back-pressure/skid: out_ready=0 and send pc=0x10 then 0x14 -> occ=2, in_ready=0, out_pc=0x10 held. Set out_ready=1 -> out_pc=0x10 then 0x14, in_ready returns to 1 after the first drain.
- Flush priority: in SKID, assert flush together with in_valid (pc=0x20) -> next cycle out_valid=0, occ=0, in_ready=1, out_instr=32'h13, and 0x20 never appears on the outputs.
- Mid-operation async reset: drop rst between clock edges while occ=2 -> out_valid=0 and occ=0 immediately, before the next posedge.
- Random handshake: randomise in_valid/out_ready over 1000 cycles against a queue model -> output sequence equals accepted sequence and occ never exceeds 2.
